ps2_keyboard_matrix: RTL and testbench

- Converts a PS/2 keyboard into the C64 8x8 keyboard matrix.
- Produces the port inputs for CIA1 and consumes that CIA's port outputs.
- Receives PS/2 frames, decodes make/break/extended codes, and keeps a 64-bit key-state matrix.
- Resolves the matrix bidirectionally against the levels CIA1 drives on PA/PB, so both normal scanning and reverse scanning work.

---
 rtl/ps2_keyboard_matrix_if.sv | 21 ++
 rtl/ps2_keyboard_matrix.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_ps2_keyboard_matrix.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_matrix_if.sv
// PS/2 line inputs plus CIA1 port A/B levels and status outputs of the keyboard bridge.
interface ps2_keyboard_matrix_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] pa_out;
  logic [7:0] pb_out;
  logic [7:0] pa_in;
  logic [7:0] pb_in;
  logic       restore_n;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data, pa_out, pb_out,
    input  pa_in, pb_in, restore_n, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data, pa_out, pb_out,
    output pa_in, pb_in, restore_n, frame_err
  );
endinterface

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 keyboard to C64 8x8 key matrix: frame receiver, scan-code decoder and
// bidirectional wire-AND resolution against the CIA1 port drive levels.
module ps2_keyboard_matrix #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 20000
) (
  input logic                   clk,
  input logic                   res_n,
  ps2_keyboard_matrix_if.slave  bus
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic       hit;
    logic       restore;
    logic [2:0] col;
    logic [2:0] row;
  } keymap_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          clk_filt;
  logic          clk_filt_d;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          din;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      clk_sync   <= '1;
      dat_sync   <= '1;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_sync   <= {clk_sync[0], bus.ps2_clk};
      dat_sync   <= {dat_sync[0], bus.ps2_data};
      clk_filt_d <= clk_filt;
      // Count consecutive samples that disagree with the filtered level
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;
  assign din  = dat_sync[1];

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  rx_state_t     state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] wdog_q;
  logic          timeout;
  logic          valid_d, err_d;
  logic          rx_valid_q;
  logic [7:0]    rx_byte_q;
  logic          frame_err_q;

  assign timeout = (state_q != RX_IDLE) && (wdog_q == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      wdog_q      <= '0;
      rx_valid_q  <= 1'b0;
      rx_byte_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      rx_valid_q  <= valid_d;
      frame_err_q <= err_d;
      if (valid_d) begin
        rx_byte_q <= shift_q;
      end
      if (fall || state_q == RX_IDLE) begin
        wdog_q <= '0;
      end else if (wdog_q != TW'(TIMEOUT)) begin
        wdog_q <= wdog_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    if (timeout) begin
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!din) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        RX_DATA: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = RX_PARITY;
          end
        end
        RX_PARITY: begin
          par_d   = din;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (din && (^{shift_q, par_q})) begin
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Scan-code set 2 to C64 matrix position (col = PA bit, row = PB bit)
  // ---------------------------------------------------------------------------
  function automatic keymap_t at(input logic [2:0] col, input logic [2:0] row);
    at = '{hit: 1'b1, restore: 1'b0, col: col, row: row};
  endfunction

  function automatic keymap_t keymap(input logic ext, input logic [7:0] code);
    keymap = '0;
    case ({ext, code})
      9'h066: keymap = at(3'd0, 3'd0);  // DEL
      9'h05A: keymap = at(3'd0, 3'd1);  // RETURN
      9'h174: keymap = at(3'd0, 3'd2);  // CRSR right
      9'h083: keymap = at(3'd0, 3'd3);  // F7
      9'h005: keymap = at(3'd0, 3'd4);  // F1
      9'h004: keymap = at(3'd0, 3'd5);  // F3
      9'h003: keymap = at(3'd0, 3'd6);  // F5
      9'h172: keymap = at(3'd0, 3'd7);  // CRSR down
      9'h026: keymap = at(3'd1, 3'd0);
      9'h01D: keymap = at(3'd1, 3'd1);
      9'h01C: keymap = at(3'd1, 3'd2);
      9'h025: keymap = at(3'd1, 3'd3);
      9'h01A: keymap = at(3'd1, 3'd4);
      9'h01B: keymap = at(3'd1, 3'd5);
      9'h024: keymap = at(3'd1, 3'd6);
      9'h012: keymap = at(3'd1, 3'd7);  // left shift
      9'h02E: keymap = at(3'd2, 3'd0);
      9'h02D: keymap = at(3'd2, 3'd1);
      9'h023: keymap = at(3'd2, 3'd2);
      9'h036: keymap = at(3'd2, 3'd3);
      9'h021: keymap = at(3'd2, 3'd4);
      9'h02B: keymap = at(3'd2, 3'd5);
      9'h02C: keymap = at(3'd2, 3'd6);
      9'h022: keymap = at(3'd2, 3'd7);
      9'h03D: keymap = at(3'd3, 3'd0);
      9'h035: keymap = at(3'd3, 3'd1);
      9'h034: keymap = at(3'd3, 3'd2);
      9'h03E: keymap = at(3'd3, 3'd3);
      9'h032: keymap = at(3'd3, 3'd4);
      9'h033: keymap = at(3'd3, 3'd5);
      9'h03C: keymap = at(3'd3, 3'd6);
      9'h02A: keymap = at(3'd3, 3'd7);
      9'h046: keymap = at(3'd4, 3'd0);
      9'h043: keymap = at(3'd4, 3'd1);
      9'h03B: keymap = at(3'd4, 3'd2);
      9'h045: keymap = at(3'd4, 3'd3);
      9'h03A: keymap = at(3'd4, 3'd4);
      9'h042: keymap = at(3'd4, 3'd5);
      9'h044: keymap = at(3'd4, 3'd6);
      9'h031: keymap = at(3'd4, 3'd7);
      9'h04E: keymap = at(3'd5, 3'd0);  // +
      9'h04D: keymap = at(3'd5, 3'd1);
      9'h04B: keymap = at(3'd5, 3'd2);
      9'h055: keymap = at(3'd5, 3'd3);  // -
      9'h049: keymap = at(3'd5, 3'd4);
      9'h04C: keymap = at(3'd5, 3'd5);  // :
      9'h054: keymap = at(3'd5, 3'd6);  // @
      9'h041: keymap = at(3'd5, 3'd7);
      9'h05D: keymap = at(3'd6, 3'd0);  // pound
      9'h05B: keymap = at(3'd6, 3'd1);  // *
      9'h052: keymap = at(3'd6, 3'd2);  // ;
      9'h16C: keymap = at(3'd6, 3'd3);  // CLR/HOME
      9'h059: keymap = at(3'd6, 3'd4);  // right shift
      9'h169: keymap = at(3'd6, 3'd5);  // =
      9'h17D: keymap = at(3'd6, 3'd6);  // up arrow
      9'h04A: keymap = at(3'd6, 3'd7);  // /
      9'h016: keymap = at(3'd7, 3'd0);
      9'h00E: keymap = at(3'd7, 3'd1);  // left arrow
      9'h014: keymap = at(3'd7, 3'd2);  // CTRL
      9'h01E: keymap = at(3'd7, 3'd3);
      9'h072: keymap = at(3'd7, 3'd3);  // keypad 2 doubles as '2'
      9'h029: keymap = at(3'd7, 3'd4);  // SPACE
      9'h011: keymap = at(3'd7, 3'd5);  // C=
      9'h015: keymap = at(3'd7, 3'd6);
      9'h076: keymap = at(3'd7, 3'd7);  // RUN/STOP
      9'h007: keymap = '{hit: 1'b1, restore: 1'b1, col: 3'd0, row: 3'd0};
      default: keymap = '0;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Decoder and key state
  // ---------------------------------------------------------------------------
  logic [63:0] key_q;
  logic        brk_q;
  logic        ext_q;
  logic        restore_n_q;
  keymap_t     km;

  assign km = keymap(ext_q, rx_byte_q);

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      key_q       <= '0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      restore_n_q <= 1'b1;
    end else if (rx_valid_q) begin
      if (rx_byte_q == 8'hE0) begin
        ext_q <= 1'b1;
      end else if (rx_byte_q == 8'hF0) begin
        brk_q <= 1'b1;
      end else if (rx_byte_q == 8'hAA || rx_byte_q == 8'h00 || rx_byte_q == 8'hFF) begin
        key_q       <= '0;
        restore_n_q <= 1'b1;
        brk_q       <= 1'b0;
        ext_q       <= 1'b0;
      end else begin
        if (km.hit && km.restore) begin
          restore_n_q <= brk_q;
        end else if (km.hit) begin
          key_q[{km.col, km.row}] <= ~brk_q;
        end
        brk_q <= 1'b0;
        ext_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Matrix resolution: a pressed key shorts its column and row, so either side
  // driven low pulls the other side low (wire-AND, ghosting included).
  // ---------------------------------------------------------------------------
  logic [7:0] row_pull;
  logic [7:0] col_pull;
  logic [7:0] pa_in_q;
  logic [7:0] pb_in_q;

  always_comb begin
    row_pull = '0;
    col_pull = '0;
    for (int unsigned c = 0; c < 8; c++) begin
      for (int unsigned r = 0; r < 8; r++) begin
        if (key_q[6'(c * 8 + r)] && !bus.pa_out[3'(c)]) begin
          row_pull[3'(r)] = 1'b1;
        end
        if (key_q[6'(c * 8 + r)] && !bus.pb_out[3'(r)]) begin
          col_pull[3'(c)] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      pa_in_q <= '1;
      pb_in_q <= '1;
    end else begin
      pa_in_q <= bus.pa_out & ~col_pull;
      pb_in_q <= bus.pb_out & ~row_pull;
    end
  end

  assign bus.pa_in     = pa_in_q;
  assign bus.pb_in     = pb_in_q;
  assign bus.restore_n = restore_n_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard_matrix.sv
// Directed bench for ps2_keyboard_matrix: table of byte/port vectors plus
// hand-written parity, watchdog, latency and mid-frame reset sequences.
module tb_ps2_keyboard_matrix;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 2000;
  localparam int unsigned HALF = 20;

  logic clk = 1'b0;
  logic res_n = 1'b1;
  always #5 clk = ~clk;

  ps2_keyboard_matrix_if bus();

  ps2_keyboard_matrix #(.FILTER_LEN(FILT), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt  = 0;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_cnt++;
  end

  typedef struct {
    logic       send;
    logic [7:0] code;
    logic [7:0] pa_out;
    logic [7:0] pb_out;
    logic [7:0] exp_pa;
    logic [7:0] exp_pb;
    logic       exp_rst;
  } vec_t;

  vec_t vecs [0:39];
  int   nv = 0;

  task automatic add(input logic s, input logic [7:0] code, input logic [7:0] pa,
                     input logic [7:0] pb, input logic [7:0] epa, input logic [7:0] epb,
                     input logic er);
    vecs[nv].send    = s;
    vecs[nv].code    = code;
    vecs[nv].pa_out  = pa;
    vecs[nv].pb_out  = pb;
    vecs[nv].exp_pa  = epa;
    vecs[nv].exp_pb  = epb;
    vecs[nv].exp_rst = er;
    nv++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
    repeat (HALF) @(negedge clk);
  endtask

  task automatic set_ports(input logic [7:0] pa, input logic [7:0] pb);
    bus.pa_out = pa;
    bus.pb_out = pb;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish, expected finish before 2ms");
    $fatal(1, "bench timeout");
  end

  initial begin
    int e0;
    int n;

    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    bus.pa_out   = 8'hFF;
    bus.pb_out   = 8'hFF;

    #2 res_n = 1'b0;
    #20;
    check("reset pa_in", bus.pa_in, 8'hFF);
    check("reset pb_in", bus.pb_in, 8'hFF);
    check("reset restore_n", bus.restore_n, 1);
    check("reset frame_err", bus.frame_err, 0);
    @(negedge clk);
    res_n = 1'b1;
    repeat (5) @(negedge clk);

    //   send code  pa_out pb_out exp_pa exp_pb restore_n
    add(1, 8'h1C, 8'hFD, 8'hFF, 8'hFD, 8'hFB, 1);  // A make, column scan
    add(1, 8'hF0, 8'hFD, 8'hFF, 8'hFD, 8'hFB, 1);
    add(1, 8'h1C, 8'hFD, 8'hFF, 8'hFD, 8'hFF, 1);  // A break
    add(1, 8'h1C, 8'hFF, 8'hFB, 8'hFD, 8'hFB, 1);  // reverse scan
    add(1, 8'h5A, 8'hFF, 8'hFB, 8'hFD, 8'hFB, 1);  // RETURN make
    add(1, 8'h5A, 8'hFF, 8'hFD, 8'hFE, 8'hFD, 1);  // typematic repeat
    add(1, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hF9, 1);
    add(1, 8'h1C, 8'h00, 8'hFF, 8'h00, 8'hFD, 1);
    add(1, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hFD, 1);
    add(1, 8'h5A, 8'h00, 8'hFF, 8'h00, 8'hFF, 1);
    add(1, 8'hE0, 8'h00, 8'hFF, 8'h00, 8'hFF, 1);
    add(1, 8'h72, 8'hFE, 8'hFF, 8'hFE, 8'h7F, 1);  // cursor down
    add(1, 8'hF0, 8'hFE, 8'hFF, 8'hFE, 8'h7F, 1);
    add(1, 8'h72, 8'h7F, 8'hFF, 8'h7F, 8'hFF, 1);  // keypad-2 break only
    add(0, 8'h00, 8'hFE, 8'hFF, 8'hFE, 8'h7F, 1);
    add(1, 8'hE0, 8'hFE, 8'hFF, 8'hFE, 8'h7F, 1);
    add(1, 8'hF0, 8'hFE, 8'hFF, 8'hFE, 8'h7F, 1);
    add(1, 8'h72, 8'hFE, 8'hFF, 8'hFE, 8'hFF, 1);
    add(1, 8'h29, 8'h00, 8'hFF, 8'h00, 8'hEF, 1);  // SPACE
    add(1, 8'h12, 8'h00, 8'hFF, 8'h00, 8'h6F, 1);  // LSHIFT
    add(1, 8'hE0, 8'h00, 8'hFF, 8'h00, 8'h6F, 1);
    add(1, 8'hAA, 8'h00, 8'hFF, 8'h00, 8'hFF, 1);  // BAT clears all
    add(1, 8'h1C, 8'hFD, 8'hFF, 8'hFD, 8'hFB, 1);  // ext cleared by BAT
    add(1, 8'hF0, 8'hFD, 8'hFF, 8'hFD, 8'hFB, 1);
    add(1, 8'h1C, 8'hFD, 8'hFF, 8'hFD, 8'hFF, 1);
    add(1, 8'h07, 8'h00, 8'hFF, 8'h00, 8'hFF, 0);  // RESTORE
    add(1, 8'hF0, 8'h00, 8'hFF, 8'h00, 8'hFF, 0);
    add(1, 8'h07, 8'h00, 8'hFF, 8'h00, 8'hFF, 1);
    add(1, 8'h59, 8'hBF, 8'hFF, 8'hBF, 8'hEF, 1);  // RSHIFT
    add(0, 8'h00, 8'hFF, 8'hEF, 8'hBF, 8'hEF, 1);
    add(1, 8'h07, 8'hFF, 8'hEF, 8'hBF, 8'hEF, 0);
    add(1, 8'hFF, 8'hBF, 8'hFF, 8'hBF, 8'hFF, 1);  // overrun clears all
    add(1, 8'hF0, 8'hFD, 8'hFF, 8'hFD, 8'hFF, 1);
    add(1, 8'h0F, 8'hFD, 8'hFF, 8'hFD, 8'hFF, 1);  // unmapped clears brk
    add(1, 8'h1C, 8'hFD, 8'hFF, 8'hFD, 8'hFB, 1);
    add(1, 8'hF0, 8'hFD, 8'hFF, 8'hFD, 8'hFB, 1);
    add(1, 8'h1C, 8'hFD, 8'hFF, 8'hFD, 8'hFF, 1);

    for (int i = 0; i < nv; i++) begin
      e0 = err_cnt;
      if (vecs[i].send) send_frame(vecs[i].code, 1'b0);
      set_ports(vecs[i].pa_out, vecs[i].pb_out);
      check($sformatf("vec%0d pa_in", i), bus.pa_in, vecs[i].exp_pa);
      check($sformatf("vec%0d pb_in", i), bus.pb_in, vecs[i].exp_pb);
      check($sformatf("vec%0d restore_n", i), bus.restore_n, vecs[i].exp_rst);
      check($sformatf("vec%0d frame_err count", i), err_cnt - e0, 0);
    end

    // Port change to matrix output is registered: one clk latency
    set_ports(8'hFF, 8'hFF);
    send_frame(8'h1C, 1'b0);
    bus.pa_out = 8'hFD;
    #1;
    check("latency pb_in before edge", bus.pb_in, 8'hFF);
    @(negedge clk);
    check("latency pb_in after edge", bus.pb_in, 8'hFB);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    set_ports(8'hFD, 8'hFF);
    check("latency release pb_in", bus.pb_in, 8'hFF);

    // Even parity over data+parity is rejected
    e0 = err_cnt;
    send_frame(8'h29, 1'b1);
    set_ports(8'h7F, 8'hFF);
    check("parity frame_err count", err_cnt - e0, 1);
    check("parity space not pressed", bus.pb_in, 8'hFF);

    // Watchdog abort after 4 data bits
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    n = 0;
    while (err_cnt == e0 && n < 3 * TMO) begin
      @(negedge clk);
      n++;
    end
    check("timeout frame_err count", err_cnt - e0, 1);
    check("timeout window", (n >= TMO - HALF && n <= TMO - HALF + 30) ? 1 : 0, 1);
    set_ports(8'h00, 8'hFF);
    check("timeout matrix unchanged", bus.pb_in, 8'hFF);
    send_frame(8'h1C, 1'b0);
    set_ports(8'hFD, 8'hFF);
    check("post-timeout A decoded", bus.pb_in, 8'hFB);
    check("post-timeout no extra err", err_cnt - e0, 1);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);

    // Reset in the middle of a frame
    send_frame(8'h07, 1'b0);
    send_frame(8'h1C, 1'b0);
    set_ports(8'hFD, 8'hFF);
    check("pre-reset pb_in", bus.pb_in, 8'hFB);
    check("pre-reset restore_n", bus.restore_n, 0);
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    bus.ps2_clk = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    res_n = 1'b0;
    #1;
    check("midframe reset pa_in", bus.pa_in, 8'hFF);
    check("midframe reset pb_in", bus.pb_in, 8'hFF);
    check("midframe reset restore_n", bus.restore_n, 1);
    check("midframe reset frame_err", bus.frame_err, 0);
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    res_n = 1'b1;
    repeat (200) @(negedge clk);
    check("post-reset err count", err_cnt - e0, 0);
    check("post-reset matrix cleared", bus.pb_in, 8'hFF);
    check("post-reset restore_n", bus.restore_n, 1);
    send_frame(8'h5A, 1'b0);
    set_ports(8'hFE, 8'hFF);
    check("post-reset RETURN decoded", bus.pb_in, 8'hFD);
    check("post-reset clean frame", err_cnt - e0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
